// File: rtl/lfsr_checker.sv
// Purpose: receive-side checker for the 4-bit LFSR pattern; self-synchronises, flags mismatches, counts errors, reports lock.
// Latency: every output is registered and reflects the word sampled on the previous rising edge of clk.
// Backpressure: none; in_valid=0 cycles are idle gaps that freeze all state. Optional macro: LFSR_CHK_AUTO_RESYNC_EN (LOST auto-exits after one cycle).
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             zero_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fsm_state
);

    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int LW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'b00,
        S_VERIFY = 2'b01,
        S_LOCKED = 2'b10,
        S_LOST   = 2'b11
    } state_t;

    // Generator next-state: shift right, feedback x[0]^x[1] into the MSB.
    function automatic logic [3:0] lfsr_nxt(input logic [3:0] x);
        return {x[0] ^ x[1], x[3], x[2], x[1]};
    endfunction

    state_t           r_state;
    logic [3:0]       r_pred;
    logic [MW-1:0]    r_match_cnt;
    logic [LW-1:0]    r_miss_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_zero_pulse;
    logic [ERR_W-1:0] r_err_count;

    state_t           w_state_nxt;
    logic [3:0]       w_pred_nxt;
    logic [MW-1:0]    w_match_nxt;
    logic [LW-1:0]    w_miss_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_err_pulse_nxt;
    logic             w_zero_word;
    logic [MW-1:0]    w_match_inc;
    logic [LW-1:0]    w_miss_inc;
    logic [ERR_W-1:0] w_err_inc;

    assign w_zero_word = in_valid && (in_data == 4'b0000);
    assign w_match_inc = r_match_cnt + MW'(1);
    assign w_miss_inc  = r_miss_cnt + LW'(1);
    assign w_err_inc   = (&r_err_count) ? r_err_count : r_err_count + ERR_W'(1);

    // Next-state, predictor, counters and pulse decisions for the current sample.
    always_comb begin
        w_state_nxt     = r_state;
        w_pred_nxt      = r_pred;
        w_match_nxt     = r_match_cnt;
        w_miss_nxt      = r_miss_cnt;
        w_err_nxt       = r_err_count;
        w_err_pulse_nxt = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (in_valid && !w_zero_word) begin
                    w_pred_nxt  = lfsr_nxt(in_data);
                    w_match_nxt = '0;
                    w_state_nxt = S_VERIFY;
                end else if (w_zero_word) begin
                    w_match_nxt = '0;
                end
            end
            S_VERIFY: begin
                if (w_zero_word) begin
                    w_match_nxt = '0;
                    w_state_nxt = S_HUNT;
                end else if (in_valid) begin
                    w_pred_nxt = lfsr_nxt(in_data);
                    if (in_data == r_pred) begin
                        if (w_match_inc == LOCK_LAST) begin
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        // Reseed from the received word and restart the match run.
                        w_match_nxt = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (in_valid) begin
                    // Flywheel: the predictor free-runs and is never reseeded here.
                    w_pred_nxt = lfsr_nxt(r_pred);
                    if (in_data == r_pred) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_nxt       = w_err_inc;
                        if (w_miss_inc == LOSS_LAST) begin
                            w_miss_nxt  = '0;
                            w_state_nxt = S_LOST;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
            end
            S_LOST: begin
`ifdef LFSR_CHK_AUTO_RESYNC_EN
                w_state_nxt = S_HUNT;
`else
                w_state_nxt = S_LOST;
`endif
                w_match_nxt = '0;
                w_miss_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase

        // Clear has priority over a same-cycle increment; the pulse is unaffected.
        if (clr_err) begin
            w_err_nxt = '0;
            if (r_state == S_LOST) begin
                w_state_nxt = S_HUNT;
            end
        end
    end

    // State register and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_pred       <= 4'b0000;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_zero_pulse <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred       <= w_pred_nxt;
            r_match_cnt  <= w_match_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_locked     <= (w_state_nxt == S_LOCKED);
            r_err_pulse  <= w_err_pulse_nxt;
            r_zero_pulse <= w_zero_word;
            r_err_count  <= w_err_nxt;
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign zero_pulse = r_zero_pulse;
    assign err_count  = r_err_count;
    assign fsm_state  = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table, mid-cycle reset, then random traffic against a sequence-index model.
// Two instances share stimulus: default parameters (A) and a narrow-counter, loss-tolerant build (B).
module tb_lfsr_checker;

`ifdef LFSR_CHK_AUTO_RESYNC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       clr_err;

    logic       a_locked, a_err_pulse, a_zero_pulse;
    logic [7:0] a_err_count;
    logic [1:0] a_state;
    logic       b_locked, b_err_pulse, b_zero_pulse;
    logic [1:0] b_err_count;
    logic [1:0] b_state;

    int checks   = 0;
    int failures = 0;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
        .locked(a_locked), .err_pulse(a_err_pulse), .zero_pulse(a_zero_pulse),
        .err_count(a_err_count), .fsm_state(a_state)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
        .locked(b_locked), .err_pulse(b_err_pulse), .zero_pulse(b_zero_pulse),
        .err_count(b_err_count), .fsm_state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the 15-word sequence and each word's position in it.
    logic [3:0] seq [15];
    int         pos_of [16];

    // mode: 0 hunt, 1 verify, 2 locked, 3 lost; pos indexes the expected next word.
    typedef struct {
        int mode;
        int pos;
        int cnt;
        int errs;
        bit ep;
        bit zp;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = 0; m.pos = 0; m.cnt = 0; m.errs = 0; m.ep = 0; m.zp = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m_in, bit v, logic [3:0] d, bit c,
                                   int lock_n, int loss_n, int emax);
        mdl_t m;
        int   old;
        bit   zero;
        m    = m_in;
        old  = m.mode;
        zero = v && (d == 4'd0);
        m.zp = zero;
        m.ep = 0;
        if (v) begin
            if (old == 0) begin
                if (!zero) begin
                    m.mode = 1; m.pos = (pos_of[d] + 1) % 15; m.cnt = 0;
                end
            end else if (old == 1) begin
                if (zero) begin
                    m.mode = 0; m.cnt = 0;
                end else if (d == seq[m.pos]) begin
                    m.pos = (m.pos + 1) % 15;
                    m.cnt++;
                    if (m.cnt == lock_n) begin
                        m.mode = 2; m.cnt = 0;
                    end
                end else begin
                    m.pos = (pos_of[d] + 1) % 15; m.cnt = 0;
                end
            end else if (old == 2) begin
                if (d == seq[m.pos]) begin
                    m.cnt = 0;
                end else begin
                    m.ep   = 1;
                    m.errs = (m.errs + 1 > emax) ? emax : m.errs + 1;
                    m.cnt++;
                    if (m.cnt == loss_n) begin
                        m.mode = 3; m.cnt = 0;
                    end
                end
                m.pos = (m.pos + 1) % 15;
            end
        end
        if (c) m.errs = 0;
        if (old == 3 && (c || AUTO)) begin
            m.mode = 0; m.cnt = 0;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_a(input string tag);
        chk({tag, " A.state"},  32'(a_state),      32'(ma.mode));
        chk({tag, " A.locked"}, 32'(a_locked),     32'(ma.mode == 2));
        chk({tag, " A.errp"},   32'(a_err_pulse),  32'(ma.ep));
        chk({tag, " A.zerop"},  32'(a_zero_pulse), 32'(ma.zp));
        chk({tag, " A.errc"},   32'(a_err_count),  32'(ma.errs));
    endtask

    task automatic cmp_b(input string tag);
        chk({tag, " B.state"},  32'(b_state),      32'(mb.mode));
        chk({tag, " B.locked"}, 32'(b_locked),     32'(mb.mode == 2));
        chk({tag, " B.errp"},   32'(b_err_pulse),  32'(mb.ep));
        chk({tag, " B.zerop"},  32'(b_zero_pulse), 32'(mb.zp));
        chk({tag, " B.errc"},   32'(b_err_count),  32'(mb.errs));
    endtask

    // Drive one cycle, advance both models, and leave time at edge+1.
    task automatic step(input bit v, input logic [3:0] d, input bit c);
        in_valid = v;
        in_data  = d;
        clr_err  = c;
        @(posedge clk);
        #1;
        ma = mstep(ma, v, d, c, 4, 3, 255);
        mb = mstep(mb, v, d, c, 4, 8, 3);
    endtask

    typedef struct {
        bit         v;
        logic [3:0] d;
        bit         c;
        logic [1:0] st;
        bit         lk;
        bit         ep;
        bit         zp;
        int         ec;
    } vec_t;

    function automatic vec_t mk(bit v, logic [3:0] d, bit c, logic [1:0] st,
                                bit lk, bit ep, bit zp, int ec);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.st = st; t.lk = lk; t.ep = ep; t.zp = zp; t.ec = ec;
        return t;
    endfunction

    vec_t vt [$];

    initial begin
        int gp;
        int r;
        bit v;
        bit c;
        logic [3:0] d;

        seq[0] = 4'b1000;
        for (int i = 1; i < 15; i++)
            seq[i] = {seq[i-1][0] ^ seq[i-1][1], seq[i-1][3:1]};
        pos_of[0] = 0;
        for (int i = 0; i < 15; i++) pos_of[seq[i]] = i;

        // Directed vectors for instance A (LOCK 4, LOSS 3, 8-bit count).
        vt.push_back(mk(1, 4'b1000, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0100, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0010, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b1001, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b1100, 0, 2'b10, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0111, 0, 2'b10, 1, 1, 0, 1));
        vt.push_back(mk(1, 4'b1011, 0, 2'b10, 1, 0, 0, 1));
        vt.push_back(mk(1, 4'b1111, 0, 2'b10, 1, 1, 0, 2));
        vt.push_back(mk(1, 4'b1111, 0, 2'b10, 1, 1, 0, 3));
        vt.push_back(mk(1, 4'b1111, 0, 2'b11, 0, 1, 0, 4));
        vt.push_back(mk(0, 4'b1000, 0, AUTO ? 2'b00 : 2'b11, 0, 0, 0, 4));
        vt.push_back(mk(1, 4'b0000, 1, 2'b00, 0, 0, 1, 0));
        vt.push_back(mk(1, 4'b1000, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0100, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(0, 4'b0000, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0010, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b1001, 0, 2'b01, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b1100, 0, 2'b10, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 0, 2'b10, 1, 1, 1, 1));
        vt.push_back(mk(1, 4'b1011, 0, 2'b10, 1, 0, 0, 1));
        vt.push_back(mk(1, 4'b1111, 1, 2'b10, 1, 1, 0, 0));
        vt.push_back(mk(1, 4'b1010, 0, 2'b10, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 0, 2'b10, 1, 1, 1, 1));

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'b0000;
        clr_err  = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset A.state",  32'(a_state), 0);
        chk("reset A.locked", 32'(a_locked), 0);
        chk("reset A.errc",   32'(a_err_count), 0);
        chk("reset A.pulses", 32'({a_err_pulse, a_zero_pulse}), 0);
        cmp_b("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].v, vt[i].d, vt[i].c);
            chk($sformatf("vec%0d state", i),  32'(a_state),      32'(vt[i].st));
            chk($sformatf("vec%0d locked", i), 32'(a_locked),     32'(vt[i].lk));
            chk($sformatf("vec%0d errp", i),   32'(a_err_pulse),  32'(vt[i].ep));
            chk($sformatf("vec%0d zerop", i),  32'(a_zero_pulse), 32'(vt[i].zp));
            chk($sformatf("vec%0d errc", i),   32'(a_err_count),  32'(vt[i].ec));
            cmp_a($sformatf("vec%0d mdl", i));
            cmp_b($sformatf("vec%0d", i));
            if (i == 9) chk("B saturated", 32'(b_err_count), 3);
        end

        // Asynchronous reset between edges while locked with a nonzero count.
        chk("pre-rst A.locked", 32'(a_locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async-rst A.locked", 32'(a_locked), 0);
        chk("async-rst A.state",  32'(a_state), 0);
        chk("async-rst A.errc",   32'(a_err_count), 0);
        ma = mdl_reset();
        mb = mdl_reset();
        in_valid = 1'b0;
        clr_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // VERIFY corner cases: reseed on a wrong word, zero word falls back to HUNT.
        step(1, 4'b0100, 0); cmp_a("vz0");
        step(1, 4'b0111, 0); cmp_a("vz1");
        step(1, 4'b0000, 0); cmp_a("vz2");
        chk("vz2 hunt", 32'(a_state), 0);

        // Random traffic: the generator sequence with gaps, corruptions and clears.
        gp = 3;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            v = (r >= 12);
            c = (r >= 97);
            if (v) begin
                d  = (r < 24) ? 4'($urandom_range(0, 15)) : seq[gp];
                gp = (gp + 1) % 15;
            end else begin
                d = 4'($urandom_range(0, 15));
            end
            step(v, d, c);
            cmp_a($sformatf("rnd%0d", i));
            cmp_b($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
